// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
//   state_t         : control FSM states (IDLE, RUN, DONE)
//   MAX_W           : widest supported operand, sizes the extension helper
//   cnt_width()     : iteration counter width for a given operand width
//   extend_operand(): sign/zero extension of an operand to twice its width
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MAX_W = 32;

  // The counter must be able to hold every bit index 0..w-1, plus headroom
  // for the terminal increment.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  // Extends the low w bits of val to 2*MAX_W bits. Bits above w replicate
  // val[w-1] when sgn is set and are zero otherwise; callers keep the low
  // 2*w bits.
  function automatic logic [2*MAX_W-1:0] extend_operand(input logic [MAX_W-1:0] val,
                                                        input int w,
                                                        input logic sgn);
    logic [2*MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < 2*MAX_W; i++) begin
      if (i < w) begin
        r[i] = val[i];
      end else begin
        r[i] = sgn & val[w-1];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mult_pp_accum.sv
// Partial-product accumulator for the shift-and-add multiplier.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clr      : load zero (takes priority over add/subtract)
//   add_en   : acc <= acc + addend
//   sub_en   : acc <= acc - addend (negative-weight MSB in signed mode)
//   addend   : multiplicand already extended and shifted by the bit index
//   acc      : running product, modulo 2^(2*WIDTH)
module mult_pp_accum #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               add_en,
  input  logic               sub_en,
  input  logic [2*WIDTH-1:0] addend,
  output logic [2*WIDTH-1:0] acc
);

  logic [2*WIDTH-1:0] acc_r;

  // Accumulator register: clear, add or subtract one partial product per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r <= '0;
    end else if (clr) begin
      acc_r <= '0;
    end else if (sub_en) begin
      acc_r <= acc_r - addend;
    end else if (add_en) begin
      acc_r <= acc_r + addend;
    end else begin
      acc_r <= acc_r;
    end
  end

  assign acc = acc_r;

endmodule

// File: rtl/seq_multiplier_shift_add.sv
// Sequential shift-and-add multiplier, one multiplier bit per clock.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   start       : one-cycle request, accepted only in IDLE
//   signed_mode : 1 = two's-complement operands (latched with start)
//   XA, Y       : multiplicand / multiplier (latched with start)
//   busy        : high while bits are being processed
//   done        : one-cycle pulse when P is updated
//   P           : 2*WIDTH-bit product, held between done pulses
// Optional build macro SEQ_MULT_EARLY_TERM_EN: unsigned operations finish as
// soon as no set multiplier bits remain (Y=0 skips RUN entirely).
module seq_multiplier_shift_add
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   XA,
  input  logic [WIDTH-1:0]   Y,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] P
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam int PW    = 2 * WIDTH;

  state_t            state_r, next_state_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [WIDTH-1:0]  xa_r, y_r;
  logic              signed_r;
  logic              busy_r, done_r;
  logic [PW-1:0]     p_r;

  logic [PW-1:0]     mcand_ext_s, addend_s, acc_s;
  logic              add_en_s, sub_en_s, acc_clr_s;
  logic              last_s, cur_bit_s;
  logic              early_run_s, early_idle_s;

  assign last_s      = (cnt_r == CNT_W'(WIDTH - 1));
  assign cur_bit_s   = |(y_r & (WIDTH'(1) << cnt_r));
  assign mcand_ext_s = PW'(extend_operand(MAX_W'(xa_r), WIDTH, signed_r));
  assign addend_s    = mcand_ext_s << cnt_r;

`ifdef SEQ_MULT_EARLY_TERM_EN
  // Nothing left to add once every multiplier bit above the current one is 0.
  assign early_run_s  = !signed_r && (((y_r >> cnt_r) >> 1) == '0);
  assign early_idle_s = !signed_mode && (Y == '0);
`else
  assign early_run_s  = 1'b0;
  assign early_idle_s = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and accumulator control.
  always_comb begin
    next_state_s = state_r;
    add_en_s     = 1'b0;
    sub_en_s     = 1'b0;
    acc_clr_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          acc_clr_s = 1'b1;
          if (early_idle_s) begin
            next_state_s = DONE;
          end else begin
            next_state_s = RUN;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        if (cur_bit_s) begin
          // The MSB of a two's-complement multiplier carries weight -2^(W-1).
          if (signed_r && last_s) begin
            sub_en_s = 1'b1;
          end else begin
            add_en_s = 1'b1;
          end
        end else begin
          add_en_s = 1'b0;
        end
        if (last_s || early_run_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = RUN;
        end
      end
      DONE: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Operand latch and bit-index counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xa_r     <= '0;
      y_r      <= '0;
      signed_r <= 1'b0;
      cnt_r    <= '0;
    end else if (state_r == IDLE && start) begin
      xa_r     <= XA;
      y_r      <= Y;
      signed_r <= signed_mode;
      cnt_r    <= '0;
    end else if (state_r == RUN) begin
      cnt_r    <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r    <= cnt_r;
    end
  end

  // Registered handshake outputs and product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      p_r    <= '0;
    end else begin
      busy_r <= (next_state_s == RUN);
      done_r <= (state_r == DONE);
      if (state_r == DONE) begin
        p_r <= acc_s;
      end else begin
        p_r <= p_r;
      end
    end
  end

  mult_pp_accum #(.WIDTH(WIDTH)) u_accum (
    .clk    (clk),
    .rst    (rst),
    .clr    (acc_clr_s),
    .add_en (add_en_s),
    .sub_en (sub_en_s),
    .addend (addend_s),
    .acc    (acc_s)
  );

  assign busy = busy_r;
  assign done = done_r;
  assign P    = p_r;

endmodule
